serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one addition.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, sampled only when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, sampled only when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result bits.
REQ-011 The block SHALL have port cout, output, 1 bit: final carry-out.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at a rising edge SHALL load a, b and cin into internal registers, clear the bit counter, and move the FSM to RUN.
REQ-014 In RUN, each rising edge SHALL add operand bit i, operand bit i and the carry register using one 1-bit full-adder cell, LSB first.
REQ-015 On each RUN edge, the sum bit SHALL be shifted into the MSB of the result shift register, the carry register SHALL update, and the counter SHALL increment.
REQ-016 After WIDTH RUN edges, the FSM SHALL enter DONE; if start was accepted at edge E0, DONE SHALL be entered at edge E(WIDTH).
REQ-017 done SHALL be 1 only in DONE, for exactly one cycle; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-018 busy SHALL be 1 in RUN only.
REQ-019 sum and cout SHALL equal (a + b + cin) mod 2^WIDTH and its carry, valid from DONE until the next accepted start.
REQ-020 sum and cout SHALL NOT be meaningful during RUN.
REQ-021 start SHALL be ignored in RUN and DONE, with no effect on the operation in progress.
REQ-022 Changes on a, b and cin outside the accept edge SHALL have no effect.
REQ-023 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.
REQ-024 Back-to-back operation: start held high SHALL be re-accepted on the first IDLE edge, giving one result every WIDTH+2 cycles.

Reset
REQ-025 rst=1 SHALL immediately force IDLE and set busy=0, done=0, sum=0, cout=0, and all internal registers and the counter to 0, independent of clk.
REQ-026 Reset asserted mid-RUN SHALL abort the operation, with no done pulse after release.
REQ-027 After rst deasserts, the first rising edge SHALL be able to accept start.

Structure
REQ-028 A shared package/include SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-029 The 1-bit adder SHALL be the existing full_adder cell, instantiated once as the only sub-module.
REQ-030 The FSM, counter, operand shift registers and carry flip-flop SHALL reside in serial_adder_ctrl.

Verification (WIDTH=8)
REQ-031 Basic add: a=0x5A, b=0x33, cin=0, start pulse -> done exactly 8 cycles after the accept edge, with sum=0x8D, cout=0.
REQ-032 Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; also a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-033 Ignored start: 0x10+0x20 started, then start with a=0xAA, b=0x55 at RUN cycle 3 -> single done with sum=0x30, cout=0; busy never drops early.
REQ-034 Reset mid-run: rst pulsed (asynchronous, between edges) at RUN cycle 4 -> busy=0, sum=0, cout=0 immediately; no done within 12 following cycles.
REQ-035 Streaming: start held high, operands 0x01+0x01 then 0x80+0x80 -> done pulses 10 cycles apart, with sum=0x02/cout=0 then sum=0x00/cout=1.
REQ-036 Random: 1000 random a, b, cin -> every result matches the reference sum; done is exactly one cycle wide.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell; the only arithmetic element of the serial adder.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum_c,
    output logic o_carry_c
);

    // Sum and majority carry of three input bits
    always_comb begin
        o_sum_c   = i_a ^ i_b ^ i_c;
        o_carry_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    end

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused WIDTH times, LSB first.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter holds 0..WIDTH, so it never wraps within one operation
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_run;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;

    logic               w_fa_sum;
    logic               w_fa_carry;

    // Shared 1-bit adder fed by the operand LSBs and the running carry
    full_adder u_full_adder (
        .i_a       (r_a[0]),
        .i_b       (r_b[0]),
        .i_c       (r_carry),
        .o_sum_c   (w_fa_sum),
        .o_carry_c (w_fa_carry)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start only matters in IDLE
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_run    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Status flags registered alongside the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == ST_RUN);
            r_done <= (w_next == ST_DONE);
        end
    end

    // Operand capture, serial shifting, carry and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
            r_carry <= w_fa_carry;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_carry;

endmodule : serial_adder_ctrl
